// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words from a host over valid/ready
// and writes them little-endian, one byte per cycle, into the byte-addressed
// instruction memory. busy holds the core off until the image is in place.
module imem_loader #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(MEM_BYTES / 4);

  logic [1:0]        state;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;

  logic [ADDR_W-1:0] start_target;
  logic [ADDR_W-1:0] wl_next;
  logic [7:0]        next_byte;

  // Clamped load length, next word count, and the byte following byte_idx
  always_comb begin
    start_target = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    wl_next      = words_loaded + ADDR_W'(1);
    next_byte    = word_q[7:0];
    case (byte_idx)
      2'd0:    next_byte = word_q[15:8];
      2'd1:    next_byte = word_q[23:16];
      2'd2:    next_byte = word_q[31:24];
      default: next_byte = word_q[7:0];
    endcase
  end

  // Load FSM; byte 0 is issued on the handshake edge so writes start at T+1
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      target       <= '0;
      base_addr    <= '0;
      word_q       <= '0;
      byte_idx     <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          mem_we <= 1'b0;
          if (start) begin
            target       <= start_target;
            base_addr    <= '0;
            words_loaded <= '0;
            if (start_target == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_ACCEPT;
              done     <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        S_ACCEPT: begin
          mem_we <= 1'b0;
          if (in_valid && in_ready) begin
            word_q    <= in_data;
            in_ready  <= 1'b0;
            byte_idx  <= 2'd0;
            state     <= S_WRITE;
            mem_we    <= 1'b1;
            mem_addr  <= base_addr;
            mem_wdata <= in_data[7:0];
          end
        end
        S_WRITE: begin
          if (byte_idx != 2'd3) begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= next_byte;
            byte_idx  <= byte_idx + 2'd1;
          end else begin
            mem_we       <= 1'b0;
            words_loaded <= wl_next;
            base_addr    <= base_addr + ADDR_W'(4);
            if (wl_next == target) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected byte writes are queued as
// words are offered and compared as the DUT issues mem_we pulses.
module tb_imem_loader;

  localparam int MEM_BYTES = 32;
  localparam int ADDR_W    = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] num_words;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] words_loaded;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  wr_t         exp_q[$];
  logic [7:0]  mem [MEM_BYTES];
  logic [31:0] image [8] = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
                             32'h019c1eb3, 32'h01bd5f33, 32'h00d67fb3, 32'h00f768b3};

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, mem_addr}, 32'hffffffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, mem_addr}, {27'd0, e.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
      end
      mem[mem_addr] = mem_wdata;
    end
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=<200000", $time);
    $fatal(1, "timeout");
  end

  task automatic push_word(input logic [ADDR_W-1:0] base, input logic [31:0] w);
    for (int unsigned b = 0; b < 4; b++) begin
      logic [31:0] sh;
      sh = w >> (8 * b);
      exp_q.push_back('{addr: base + ADDR_W'(b), data: sh[7:0]});
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] n);
    start = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one word, check the 4-cycle in_ready gap, return at cycle T+5
  task automatic send_word(input logic [ADDR_W-1:0] base, input logic [31:0] w,
                           input bit last, input logic [ADDR_W-1:0] exp_wl);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("handshake_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      push_word(base, w);
      @(negedge clk);
      in_valid = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        check("rdy_low_in_write", {31'd0, in_ready}, 32'd0);
        check("we_in_write", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
      end
      check("we_after_word", {31'd0, mem_we}, 32'd0);
      if (last) begin
        check("done_after_last", {31'd0, done}, 32'd1);
        check("busy_after_last", {31'd0, busy}, 32'd0);
        check("rdy_after_last", {31'd0, in_ready}, 32'd0);
        check("words_loaded", {27'd0, words_loaded}, {27'd0, exp_wl});
      end else begin
        check("rdy_next_word", {31'd0, in_ready}, 32'd1);
        check("busy_mid_load", {31'd0, busy}, 32'd1);
      end
    end
  endtask

  task automatic check_fetch(input int unsigned nw);
    for (int unsigned i = 0; i < nw; i++) begin
      int unsigned pc;
      pc = 4 * i;
      check("fetch_word", {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}, image[i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    for (int unsigned i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wl", {27'd0, words_loaded}, 32'd0);
    check("rst_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two words back-to-back
    do_start(5'd2);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_rdy", {31'd0, in_ready}, 32'd1);
    send_word(5'd0, 32'h00940333, 1'b0, 5'd0);
    send_word(5'd4, 32'h413903b3, 1'b1, 5'd2);

    // Full image, then fetch-side readback
    do_start(5'd8);
    check("reload_done_clear", {31'd0, done}, 32'd0);
    for (int unsigned i = 0; i < 8; i++)
      send_word(ADDR_W'(4 * i), image[i], i == 7, 5'd8);
    check_fetch(8);

    // Clamp: 12 requested, 8 loaded, no further acceptance
    do_start(5'd12);
    for (int unsigned i = 0; i < 8; i++)
      send_word(ADDR_W'(4 * i), image[7 - i], i == 7, 5'd8);
    in_valid = 1'b1;
    in_data  = 32'h55aa55aa;
    repeat (3) begin
      @(negedge clk);
      check("clamp_rdy_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // Zero length
    do_start(5'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_rdy", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_we", {31'd0, mem_we}, 32'd0);

    // Host stall with a start pulse while busy
    do_start(5'd1);
    for (int unsigned i = 0; i < 7; i++) begin
      if (i == 3) begin
        start = 1'b1;
        num_words = 5'd5;
      end else begin
        start = 1'b0;
      end
      check("stall_rdy", {31'd0, in_ready}, 32'd1);
      check("stall_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    send_word(5'd0, 32'hdeadbeef, 1'b1, 5'd1);

    // Reload after DONE
    do_start(5'd1);
    check("reload2_done_clear", {31'd0, done}, 32'd0);
    send_word(5'd0, 32'h12345678, 1'b1, 5'd1);
    check("reload_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h12345678);

    // Reset in the 2nd write cycle of word 1: only its first two bytes land
    do_start(5'd2);
    send_word(5'd0, 32'hcafef00d, 1'b0, 5'd0);
    in_valid = 1'b1;
    in_data  = 32'h87654321;
    exp_q.push_back('{addr: 5'd4, data: 8'h21});
    exp_q.push_back('{addr: 5'd5, data: 8'h43});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_wl", {27'd0, words_loaded}, 32'd0);
    check("mid_rst_addr", {27'd0, mem_addr}, 32'd0);
    check("mid_rst_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_we", {31'd0, mem_we}, 32'd0);
    do_start(5'd1);
    send_word(5'd0, 32'ha5c30f96, 1'b1, 5'd1);
    check("post_rst_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'ha5c30f96);
    check("partial_word_mem", {16'd0, mem[5], mem[4]}, 32'h00004321);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
